// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner.
// Drives one active-low row at a time. Each row is held for SETTLE_CYCLES
// clocks and then its columns are sampled in a single SAMPLE cycle. The
// sampled keys update a registered 16-bit held-key vector and a one-cycle
// press pulse per key.
// Optional feature macro: KEYPAD_DEBOUNCE_EN. When it is defined, each key
// owns a disagreement counter and only flips after DEBOUNCE_SCANS consecutive
// disagreeing samples. When it is undefined, each sample is copied straight
// into the state bits.
module keypad_scanner #(
   parameter int unsigned SETTLE_CYCLES  = 1000,
   parameter int unsigned DEBOUNCE_SCANS = 4
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [3:0]  col_in,
   output logic [3:0]  row_out,
   output logic [15:0] key_state_out,
   output logic [15:0] key_press_out,
   output logic        scan_done_out
);

   localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(SETTLE_CYCLES - 1);

   typedef enum logic {
      SETTLE,
      SAMPLE
   } state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] settleCnt_q, settleCnt_d;
   logic [1:0]      rowIdx_q;
   logic [1:0]      rowNext;
   logic [3:0]      rowOut_q;
   logic [3:0]      colMeta_q, colSync_q;
   logic [15:0]     keyState_q, keyState_d;
   logic [15:0]     keyPress_q;
   logic            scanDone_q;
   logic            sampleEn;
   logic [3:0]      raw;

   assign rowNext       = rowIdx_q + 2'd1;
   assign raw           = ~colSync_q;
   assign row_out       = rowOut_q;
   assign key_state_out = keyState_q;
   assign key_press_out = keyPress_q;
   assign scan_done_out = scanDone_q;

   // Two-flop synchronizer for the asynchronous, pulled-up column lines
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         colMeta_q <= 4'hF;
         colSync_q <= 4'hF;
      end else begin
         colMeta_q <= col_in;
         colSync_q <= colMeta_q;
      end
   end

   // FSM state register
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q <= SETTLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: settle for SETTLE_CYCLES cycles, then sample for one cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         SETTLE:  if (settleCnt_q == LastCnt) state_d = SAMPLE;
         SAMPLE:  state_d = SETTLE;
         default: state_d = SETTLE;
      endcase
   end

   // FSM outputs: the sample strobe and the next settle count
   always_comb begin
      sampleEn    = 1'b0;
      settleCnt_d = settleCnt_q;
      case (state_q)
         SETTLE: settleCnt_d = settleCnt_q + 1'b1;
         SAMPLE: begin
            sampleEn    = 1'b1;
            settleCnt_d = '0;
         end
         default: settleCnt_d = '0;
      endcase
   end

   // Settle counter register
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         settleCnt_q <= '0;
      end else begin
         settleCnt_q <= settleCnt_d;
      end
   end

   // Row index and registered row drive; the new row appears the cycle after SAMPLE
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         rowIdx_q <= 2'd0;
         rowOut_q <= 4'b1110;
      end else if (sampleEn) begin
         rowIdx_q <= rowNext;
         rowOut_q <= ~(4'b0001 << rowNext);
      end
   end

`ifdef KEYPAD_DEBOUNCE_EN
   localparam logic [3:0] DebLimit = 4'(DEBOUNCE_SCANS);

   logic [3:0] debCnt_q [16];
   logic [3:0] debCnt_d [16];

   // Debounce: a key flips only after DebLimit consecutive disagreeing samples of its row
   always_comb begin
      logic [3:0] cntInc;
      cntInc     = '0;
      keyState_d = keyState_q;
      for (int i = 0; i < 16; i++) begin
         debCnt_d[i] = debCnt_q[i];
         if (sampleEn && (rowIdx_q == 2'(i / 4))) begin
            if (raw[i % 4] == keyState_q[i]) begin
               debCnt_d[i] = '0;
            end else begin
               cntInc = debCnt_q[i] + 4'd1;
               if (cntInc == DebLimit) begin
                  keyState_d[i] = ~keyState_q[i];
                  debCnt_d[i]   = '0;
               end else begin
                  debCnt_d[i] = cntInc;
               end
            end
         end
      end
   end

   // Debounce counter registers; reset discards any partial progress
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         for (int i = 0; i < 16; i++) debCnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < 16; i++) debCnt_q[i] <= debCnt_d[i];
      end
   end
`else
   // DEBOUNCE_SCANS has no effect without debounce; reduced here so it is still referenced
   logic unusedDebounceScans;
   assign unusedDebounceScans = ^DEBOUNCE_SCANS;

   // No debounce: the sampled row is copied straight into its four state bits
   always_comb begin
      keyState_d = keyState_q;
      if (sampleEn) begin
         keyState_d[{rowIdx_q, 2'b00} +: 4] = raw;
      end
   end
`endif

   // Registered outputs: held-key vector, rising-edge press pulses, frame-done pulse
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         keyState_q <= 16'h0000;
         keyPress_q <= 16'h0000;
         scanDone_q <= 1'b0;
      end else begin
         keyState_q <= keyState_d;
         keyPress_q <= keyState_d & ~keyState_q;
         scanDone_q <= sampleEn && (rowIdx_q == 2'd3);
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner with SETTLE_CYCLES=4,
// DEBOUNCE_SCANS=3. A small keypad model pulls column lines low for pressed
// keys on the currently driven row. Expected values adapt to whether
// KEYPAD_DEBOUNCE_EN is defined. Cycle numbers count falling edges after
// reset release; row r of frame f is sampled in cycle 20f+5r+4 and its
// result is visible in cycle 20f+5r+5.
module tb_keypad_scanner;

`ifdef KEYPAD_DEBOUNCE_EN
   localparam bit DEB = 1'b1;
`else
   localparam bit DEB = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  colIn;
   logic [3:0]  rowOut;
   logic [15:0] keyState;
   logic [15:0] keyPress;
   logic        scanDone;
   logic [15:0] pressedKeys = 16'h0000;
   logic [15:0] pressSeen   = 16'h0000;
   int          checks = 0;
   int          errors = 0;
   int          cyc    = 0;

   keypad_scanner #(
      .SETTLE_CYCLES (4),
      .DEBOUNCE_SCANS(3)
   ) dut (
      .clk_in       (clk),
      .rst_in       (rst),
      .col_in       (colIn),
      .row_out      (rowOut),
      .key_state_out(keyState),
      .key_press_out(keyPress),
      .scan_done_out(scanDone)
   );

   // Free-running clock, 10 time units per period
   always #5 clk = ~clk;

   // Keypad model: a pressed key on a driven (low) row pulls its column low
   always_comb begin
      colIn = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (pressedKeys[r*4+c] && !rowOut[r]) colIn[c] = 1'b0;
         end
      end
   end

   // Watchdog so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic nextCycle();
      @(negedge clk);
      cyc++;
      pressSeen |= keyPress;
   endtask

   task automatic waitUntil(input int target);
      if (target < cyc) begin
         checks++;
         errors++;
         $error("[TB] FAIL waitUntil observed=%0d expected=%0d", cyc, target);
      end else begin
         while (cyc < target) nextCycle();
      end
   endtask

   task automatic applyStimulus(input logic [15:0] keys);
      pressedKeys = keys;
   endtask

   task automatic applyReset(input logic [15:0] keys);
      rst = 1'b1;
      pressedKeys = keys;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      cyc = 0;
      pressSeen = 16'h0000;
   endtask

   initial begin
      int fullCyc;
      int relCyc;

      // Reset values while reset is held
      @(negedge clk);
      checkOutput("rst row",   16'(rowOut),   16'h000E);
      checkOutput("rst state", keyState,      16'h0000);
      checkOutput("rst press", keyPress,      16'h0000);
      checkOutput("rst done",  16'(scanDone), 16'h0000);

      // Idle scanning, no keys
      $display("[TB] idle scan");
      applyReset(16'h0000);
      waitUntil(0);  checkOutput("idle row c0",  16'(rowOut), 16'h000E);
      waitUntil(4);  checkOutput("idle row c4",  16'(rowOut), 16'h000E);
      waitUntil(5);  checkOutput("idle row c5",  16'(rowOut), 16'h000D);
      waitUntil(10); checkOutput("idle row c10", 16'(rowOut), 16'h000B);
      waitUntil(15); checkOutput("idle row c15", 16'(rowOut), 16'h0007);
      waitUntil(19); checkOutput("idle done c19", 16'(scanDone), 16'h0000);
      waitUntil(20); checkOutput("idle done c20", 16'(scanDone), 16'h0001);
                     checkOutput("idle row c20",  16'(rowOut),   16'h000E);
      waitUntil(21); checkOutput("idle done c21", 16'(scanDone), 16'h0000);
      waitUntil(40); checkOutput("idle done c40", 16'(scanDone), 16'h0001);
                     checkOutput("idle state",    keyState,      16'h0000);
                     checkOutput("idle pressSeen", pressSeen,    16'h0000);

      // Key (1,2) held from reset
      $display("[TB] hold key 6");
      applyReset(16'h0040);
      fullCyc = DEB ? 50 : 10;
      waitUntil(fullCyc - 1); checkOutput("k6 state before", keyState, 16'h0000);
      waitUntil(fullCyc);     checkOutput("k6 state set",    keyState, 16'h0040);
                              checkOutput("k6 press",        keyPress, 16'h0040);
      waitUntil(fullCyc + 1); checkOutput("k6 press once",   keyPress, 16'h0000);
                              checkOutput("k6 state held",   keyState, 16'h0040);

      // Key (0,0) pressed for two frames then released
      $display("[TB] short press key 0");
      applyReset(16'h0001);
      waitUntil(25); checkOutput("k0 short c25", keyState, DEB ? 16'h0000 : 16'h0001);
      waitUntil(40); applyStimulus(16'h0000);
      waitUntil(45); checkOutput("k0 short c45", keyState, 16'h0000);
      waitUntil(65); checkOutput("k0 short c65", keyState, 16'h0000);
                     checkOutput("k0 short pressSeen", pressSeen, DEB ? 16'h0000 : 16'h0001);

      // Keys 0 and 15 held, then 15 released
      $display("[TB] keys 0 and 15");
      applyReset(16'h8001);
      fullCyc = DEB ? 60 : 20;
      relCyc  = DEB ? 120 : 80;
      waitUntil(fullCyc); checkOutput("k0k15 state", keyState, 16'h8001);
                          checkOutput("k0k15 press", keyPress, 16'h8000);
      waitUntil(60);      checkOutput("k0k15 state c60", keyState, 16'h8001);
      applyStimulus(16'h0001);
      pressSeen = 16'h0000;
      waitUntil(relCyc - 1); checkOutput("k15 rel before", keyState, 16'h8001);
      waitUntil(relCyc);     checkOutput("k15 rel state",  keyState, 16'h0001);
                             checkOutput("k15 rel done",   16'(scanDone), 16'h0001);
      waitUntil(relCyc + 1); checkOutput("k15 rel nopress", pressSeen, 16'h0000);

      // Reset between the 2nd and 3rd row-1 sample of a held key
      $display("[TB] mid-frame reset");
      applyReset(16'h0040);
      waitUntil(35); checkOutput("mid pre state", keyState, DEB ? 16'h0000 : 16'h0040);
                     checkOutput("mid pre row",   16'(rowOut), 16'h0007);
      rst = 1'b1;
      #1;
      checkOutput("mid rst row",   16'(rowOut),   16'h000E);
      checkOutput("mid rst state", keyState,      16'h0000);
      checkOutput("mid rst press", keyPress,      16'h0000);
      checkOutput("mid rst done",  16'(scanDone), 16'h0000);
      applyReset(16'h0040);
      waitUntil(9);  checkOutput("mid post c9",  keyState, 16'h0000);
      waitUntil(10); checkOutput("mid post c10", keyState, DEB ? 16'h0000 : 16'h0040);
      waitUntil(49); checkOutput("mid post c49", keyState, DEB ? 16'h0000 : 16'h0040);
      waitUntil(50); checkOutput("mid post c50", keyState, 16'h0040);

      // Key (1,1) held for one frame
      $display("[TB] one-frame key 5");
      applyReset(16'h0020);
      waitUntil(9);  checkOutput("k5 c9",  keyState, 16'h0000);
      waitUntil(10); checkOutput("k5 c10", keyState, DEB ? 16'h0000 : 16'h0020);
      waitUntil(20); applyStimulus(16'h0000);
      waitUntil(29); checkOutput("k5 c29", keyState, DEB ? 16'h0000 : 16'h0020);
      waitUntil(30); checkOutput("k5 c30", keyState, 16'h0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
